// File: rtl/la_out_ctrl_pkg.sv
// la_out_ctrl_pkg: register map, CTRL/STATUS bit positions and bus FSM states for la_out_ctrl
package la_out_ctrl_pkg;

    localparam logic [2:0] ADDR_SHADOW0 = 3'd0;
    localparam logic [2:0] ADDR_SHADOW1 = 3'd1;
    localparam logic [2:0] ADDR_SHADOW2 = 3'd2;
    localparam logic [2:0] ADDR_SHADOW3 = 3'd3;
    localparam logic [2:0] ADDR_CTRL    = 3'd4;
    localparam logic [2:0] ADDR_STATUS  = 3'd5;

    localparam int CTRL_COMMIT    = 0;
    localparam int CTRL_CLEAR     = 1;
    localparam int CTRL_AUTO      = 2;
    localparam int STATUS_PENDING = 0;
    localparam int STATUS_CNT_LSB = 8;

    typedef enum logic {
        ST_IDLE,
        ST_ACK
    } wb_state_t;

endpackage

// File: rtl/la_out_ctrl_if.sv
// la_out_ctrl_if: Wishbone classic slave bundle between the management bus and la_out_ctrl
interface la_out_ctrl_if;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [2:0]  wb_adr_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/la_out_ctrl_wb.sv
// la_out_ctrl_wb: Wishbone front end -- two-state access FSM, ack, registered read mux, write strobes
module la_out_ctrl_wb
    import la_out_ctrl_pkg::*;
(
    input  logic           sys_clk,
    input  logic           sys_rst_n,
    la_out_ctrl_if.slave   bus,
    input  logic [127:0]   shadow,
    input  logic           auto_en,
    input  logic           pending,
    input  logic [7:0]     count,
    output logic [3:0]     shadow_we,
    output logic           ctrl_we
);

    wb_state_t   state, state_nxt;
    logic        access;
    logic [31:0] rd_mux;
    logic [31:0] rd_q;

    // access decode, next state, write strobes and read mux; side effects land on the IDLE->ACK edge
    always_comb begin
        access    = (state == ST_IDLE) && bus.wb_cyc_i && bus.wb_stb_i;
        state_nxt = state;
        shadow_we = '0;
        ctrl_we   = 1'b0;
        rd_mux    = '0;
        if (state == ST_ACK)
            state_nxt = ST_IDLE;
        else if (access)
            state_nxt = ST_ACK;
        if (access && bus.wb_we_i && !bus.wb_adr_i[2])
            shadow_we[bus.wb_adr_i[1:0]] = 1'b1;
        ctrl_we = access && bus.wb_we_i && (bus.wb_adr_i == ADDR_CTRL) && bus.wb_sel_i[0];
        if (!bus.wb_adr_i[2])
            rd_mux = shadow[{bus.wb_adr_i[1:0], 5'd0} +: 32];
        else if (bus.wb_adr_i == ADDR_CTRL)
            rd_mux[CTRL_AUTO] = auto_en;
        else if (bus.wb_adr_i == ADDR_STATUS) begin
            rd_mux[STATUS_PENDING] = pending;
            rd_mux[STATUS_CNT_LSB +: 8] = count;
        end
    end

    // state register and read data captured at access time, zero outside read acks
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= ST_IDLE;
            rd_q  <= '0;
        end else begin
            state <= state_nxt;
            rd_q  <= (access && !bus.wb_we_i) ? rd_mux : 32'd0;
        end
    end

    assign bus.wb_dat_o = rd_q;
    assign bus.wb_ack_o = (state == ST_ACK) && bus.wb_cyc_i && bus.wb_stb_i;

endmodule

// File: rtl/la_out_ctrl.sv
// la_out_ctrl: shadowed 128-bit LA output with atomic commit; optional LA_OUT_CTRL_SYNC_EN gates loads on la_sync_i
module la_out_ctrl
    import la_out_ctrl_pkg::*;
#(
    parameter logic [127:0] RST_VALUE = '0
) (
    input  logic           sys_clk,
    input  logic           sys_rst_n,
    la_out_ctrl_if.slave   bus,
    input  logic           la_sync_i,
    output logic [127:0]   la_out,
    output logic           la_commit_o
);

    logic [127:0] shadow, shadow_nxt;
    logic [3:0]   shadow_we;
    logic         ctrl_we;
    logic         auto_en;
    logic         pending;
    logic [7:0]   count;
    logic         sync;
    logic         clear;
    logic         commit_req;
    logic         load;

`ifdef LA_OUT_CTRL_SYNC_EN
    assign sync = la_sync_i;
`else
    assign sync = la_sync_i | 1'b1;
`endif

    la_out_ctrl_wb u_wb (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus),
        .shadow    (shadow),
        .auto_en   (auto_en),
        .pending   (pending),
        .count     (count),
        .shadow_we (shadow_we),
        .ctrl_we   (ctrl_we)
    );

    assign clear      = ctrl_we && bus.wb_dat_i[CTRL_CLEAR];
    assign commit_req = (ctrl_we && bus.wb_dat_i[CTRL_COMMIT]) || (shadow_we[3] && auto_en);
    assign load       = pending && sync;

    // byte-lane merge of a bus write into the shadow copy
    always_comb begin
        shadow_nxt = shadow;
        for (int w = 0; w < 4; w++)
            for (int b = 0; b < 4; b++)
                if (shadow_we[w] && bus.wb_sel_i[b])
                    shadow_nxt[32*w + 8*b +: 8] = bus.wb_dat_i[8*b +: 8];
    end

    // shadow, live output, pending flag, commit pulse and count; CLEAR overrides any commit activity
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            shadow      <= RST_VALUE;
            la_out      <= RST_VALUE;
            pending     <= 1'b0;
            la_commit_o <= 1'b0;
            count       <= '0;
        end else if (clear) begin
            shadow      <= RST_VALUE;
            la_out      <= RST_VALUE;
            pending     <= 1'b0;
            la_commit_o <= 1'b0;
        end else begin
            shadow      <= shadow_nxt;
            pending     <= commit_req || (pending && !load);
            la_commit_o <= load;
            if (load) begin
                la_out <= shadow;
                count  <= count + 8'd1;
            end
        end
    end

    // sticky AUTO bit, rewritten by every CTRL write
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            auto_en <= 1'b0;
        else if (ctrl_we)
            auto_en <= bus.wb_dat_i[CTRL_AUTO];
    end

endmodule

// File: tb/tb_la_out_ctrl.sv
// tb_la_out_ctrl: table vectors, pulse/reset/wrap sequences and random traffic against a register-level model
module tb_la_out_ctrl;
    import la_out_ctrl_pkg::*;

    logic         sys_clk = 1'b0;
    logic         sys_rst_n = 1'b0;
    logic         la_sync_i = 1'b1;
    logic [127:0] la_out;
    logic         la_commit_o;
    int           n_chk = 0;
    int           n_fail = 0;
    int           pulses = 0;

    la_out_ctrl_if bus ();

    la_out_ctrl dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .bus         (bus),
        .la_sync_i   (la_sync_i),
        .la_out      (la_out),
        .la_commit_o (la_commit_o)
    );

    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk) if (la_commit_o) pulses++;

    logic [31:0]  m_sh [4];
    logic [127:0] m_live;
    logic         m_auto;
    logic [7:0]   m_cnt;
    int           m_pulses = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 4; i++) m_sh[i] = '0;
        m_live = '0;
        m_auto = 1'b0;
        m_cnt  = '0;
    endtask

    function automatic logic [127:0] m_pack();
        return {m_sh[3], m_sh[2], m_sh[1], m_sh[0]};
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] a);
        if (a < 3'd4) return m_sh[a[1:0]];
        if (a == 3'd4) return {29'd0, m_auto, 2'd0};
        if (a == 3'd5) return {16'd0, m_cnt, 8'd0};
        return 32'd0;
    endfunction

    task automatic m_write(input logic [2:0] a, input logic [3:0] s, input logic [31:0] d);
        logic req;
        req = 1'b0;
        if (a < 3'd4) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) m_sh[a[1:0]][8*b +: 8] = d[8*b +: 8];
            req = (a == 3'd3) && m_auto;
        end else if (a == 3'd4 && s[0]) begin
            if (d[1]) begin
                for (int i = 0; i < 4; i++) m_sh[i] = '0;
                m_live = '0;
            end else begin
                req = d[0];
            end
            m_auto = d[2];
        end
        if (req) begin
            m_live = m_pack();
            m_cnt++;
            m_pulses++;
        end
    endtask

    task automatic xfer(input logic [2:0] a, input logic we, input logic [3:0] s, input logic [31:0] d,
                        output logic [31:0] rd);
        int n = 0;
        @(negedge sys_clk);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = we;
        bus.wb_adr_i = a;
        bus.wb_sel_i = s;
        bus.wb_dat_i = d;
        do begin
            @(posedge sys_clk);
            #1;
            n++;
        end while (!bus.wb_ack_o && n < 8);
        chk("ack", 128'(bus.wb_ack_o), 128'd1);
        rd = bus.wb_dat_o;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
    endtask

    task automatic op(input logic [2:0] a, input logic we, input logic [3:0] s, input logic [31:0] d,
                      output logic [31:0] rd, output logic [127:0] la, output logic [31:0] exp_rd);
        exp_rd = m_read(a);
        xfer(a, we, s, d, rd);
        if (we) m_write(a, s, d);
        @(posedge sys_clk);
        #1;
        la = la_out;
        @(negedge sys_clk);
        #1;
        chk("commit_pulses", 128'(pulses), 128'(m_pulses));
    endtask

    typedef struct {
        logic [2:0]   adr;
        logic         we;
        logic [3:0]   sel;
        logic [31:0]  dat;
        logic [31:0]  rd;
        logic [127:0] la;
    } vec_t;

    vec_t tbl [20];

    initial begin
        logic [31:0]  rd, exp_rd;
        logic [127:0] la, l1, l2, snap;
        logic [7:0]   c0;
        l1 = 128'h44444444_33333333_22222222_11111111;
        l2 = 128'hDEADBEEF_33333333_22222222_11111111;
        tbl[0]  = '{3'd5, 1'b0, 4'hF, 32'h0,        32'h0,        128'd0};
        tbl[1]  = '{3'd0, 1'b1, 4'hF, 32'h11111111, 32'h0,        128'd0};
        tbl[2]  = '{3'd1, 1'b1, 4'hF, 32'h22222222, 32'h0,        128'd0};
        tbl[3]  = '{3'd2, 1'b1, 4'hF, 32'h33333333, 32'h0,        128'd0};
        tbl[4]  = '{3'd3, 1'b1, 4'hF, 32'h44444444, 32'h0,        128'd0};
        tbl[5]  = '{3'd4, 1'b1, 4'hF, 32'h1,        32'h0,        l1};
        tbl[6]  = '{3'd5, 1'b0, 4'hF, 32'h0,        32'h100,      l1};
        tbl[7]  = '{3'd4, 1'b1, 4'hF, 32'h4,        32'h0,        l1};
        tbl[8]  = '{3'd3, 1'b1, 4'hF, 32'hDEADBEEF, 32'h0,        l2};
        tbl[9]  = '{3'd5, 1'b0, 4'hF, 32'h0,        32'h200,      l2};
        tbl[10] = '{3'd4, 1'b0, 4'hF, 32'h0,        32'h4,        l2};
        tbl[11] = '{3'd0, 1'b1, 4'h3, 32'hAABBCCDD, 32'h0,        l2};
        tbl[12] = '{3'd0, 1'b0, 4'hF, 32'h0,        32'h1111CCDD, l2};
        tbl[13] = '{3'd4, 1'b1, 4'hF, 32'h3,        32'h0,        128'd0};
        tbl[14] = '{3'd5, 1'b0, 4'hF, 32'h0,        32'h200,      128'd0};
        tbl[15] = '{3'd0, 1'b0, 4'hF, 32'h0,        32'h0,        128'd0};
        tbl[16] = '{3'd6, 1'b1, 4'hF, 32'hFFFFFFFF, 32'h0,        128'd0};
        tbl[17] = '{3'd6, 1'b0, 4'hF, 32'h0,        32'h0,        128'd0};
        tbl[18] = '{3'd7, 1'b0, 4'hF, 32'h0,        32'h0,        128'd0};
        tbl[19] = '{3'd4, 1'b0, 4'hF, 32'h0,        32'h0,        128'd0};

        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        bus.wb_adr_i = '0;
        bus.wb_sel_i = '0;
        bus.wb_dat_i = '0;
        m_reset();

        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_la_out", la_out, 128'd0);
        chk("rst_ack", 128'(bus.wb_ack_o), 128'd0);
        chk("rst_dat_o", 128'(bus.wb_dat_o), 128'd0);
        chk("rst_commit", 128'(la_commit_o), 128'd0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            op(tbl[i].adr, tbl[i].we, tbl[i].sel, tbl[i].dat, rd, la, exp_rd);
            if (!tbl[i].we) chk($sformatf("tbl%0d_rd", i), 128'(rd), 128'(tbl[i].rd));
            chk($sformatf("tbl%0d_la", i), la, tbl[i].la);
        end

        op(3'd0, 1'b1, 4'hF, 32'hCAFE0001, rd, la, exp_rd);
        xfer(3'd4, 1'b1, 4'hF, 32'h1, rd);
        m_write(3'd4, 4'hF, 32'h1);
        chk("pulse_before", 128'(la_commit_o), 128'd0);
        chk("la_before_load", la_out, 128'd0);
        @(posedge sys_clk);
        #1;
        chk("pulse_high", 128'(la_commit_o), 128'd1);
        chk("la_after_load", la_out, m_live);
        @(posedge sys_clk);
        #1;
        chk("pulse_low", 128'(la_commit_o), 128'd0);
        @(negedge sys_clk);
        #1;
        chk("pulse_count", 128'(pulses), 128'(m_pulses));

        c0 = m_cnt;
        for (int i = 0; i < 256; i++) op(3'd4, 1'b1, 4'h1, 32'h1, rd, la, exp_rd);
        op(3'd5, 1'b0, 4'hF, 32'h0, rd, la, exp_rd);
        chk("wrap_count", 128'(rd[15:8]), 128'(c0));
        chk("wrap_status", 128'(rd), 128'(exp_rd));

        for (int i = 0; i < 200; i++) begin
            logic [2:0]  a;
            logic        we;
            logic [3:0]  s;
            logic [31:0] d;
            a  = 3'($urandom_range(0, 7));
            we = 1'($urandom_range(0, 1));
            s  = 4'($urandom);
            d  = $urandom;
            if (a == 3'd4 && $urandom_range(0, 3) != 0) d[1] = 1'b0;
            op(a, we, s, d, rd, la, exp_rd);
            if (!we) chk($sformatf("rand%0d_rd", i), 128'(rd), 128'(exp_rd));
            chk($sformatf("rand%0d_la", i), la, m_live);
        end

`ifdef LA_OUT_CTRL_SYNC_EN
        op(3'd4, 1'b1, 4'h1, 32'h0, rd, la, exp_rd);
        op(3'd0, 1'b1, 4'hF, 32'h12345678, rd, la, exp_rd);
        snap = la_out;
        la_sync_i = 1'b0;
        xfer(3'd4, 1'b1, 4'hF, 32'h1, rd);
        repeat (10) @(posedge sys_clk);
        #1;
        chk("sync_hold_la", la_out, snap);
        chk("sync_hold_pulse", 128'(la_commit_o), 128'd0);
        xfer(3'd5, 0, 4'hF, 32'h0, rd);
        chk("sync_pending_status", 128'(rd), 128'({16'd0, m_cnt, 8'd1}));
        xfer(3'd1, 1'b1, 4'hF, 32'hA5A5A5A5, rd);
        m_write(3'd1, 4'hF, 32'hA5A5A5A5);
        repeat (3) @(posedge sys_clk);
        #1;
        chk("sync_hold_la2", la_out, snap);
        @(negedge sys_clk);
        la_sync_i = 1'b1;
        @(posedge sys_clk);
        #1;
        m_live = m_pack();
        m_cnt++;
        m_pulses++;
        chk("sync_load_la", la_out, m_live);
        chk("sync_load_pulse", 128'(la_commit_o), 128'd1);
        @(negedge sys_clk);
        #1;
        chk("sync_pulse_count", 128'(pulses), 128'(m_pulses));
`endif

        op(3'd0, 1'b1, 4'hF, 32'h5A5A0F0F, rd, la, exp_rd);
        op(3'd4, 1'b1, 4'h1, 32'h1, rd, la, exp_rd);
        chk("pre_reset_la", la, m_live);
        @(negedge sys_clk);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = 1'b0;
        bus.wb_adr_i = 3'd5;
        for (int n = 0; n < 8 && !bus.wb_ack_o; n++) begin
            @(posedge sys_clk);
            #1;
        end
        chk("mid_ack_seen", 128'(bus.wb_ack_o), 128'd1);
        sys_rst_n = 1'b0;
        #1;
        chk("mid_rst_ack", 128'(bus.wb_ack_o), 128'd0);
        chk("mid_rst_la", la_out, 128'd0);
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        m_reset();
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        op(3'd5, 1'b0, 4'hF, 32'h0, rd, la, exp_rd);
        chk("post_rst_status", 128'(rd), 128'd0);
        op(3'd4, 1'b0, 4'hF, 32'h0, rd, la, exp_rd);
        chk("post_rst_ctrl", 128'(rd), 128'(exp_rd));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
